// File: rtl/arm_pipe_chain.sv
// In-order pipeline register chain carrying valid, PC and payload through STAGES
// registers, with per-stage stall, bubble insertion, partial flush and perf counters.
module arm_pipe_chain #(
    parameter int STAGES = 4,
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [STAGES-1:0] stall_req,
    input  logic [STAGES-1:0] flush,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] fl;
    logic [STAGES-1:0] bub;

    logic [STAGES-1:0] vld_p;
    logic [PC_W-1:0]   pc_p   [STAGES];
    logic [DATA_W-1:0] data_p [STAGES];

    logic [STAGES-1:0] src_vld;
    logic [PC_W-1:0]   src_pc   [STAGES];
    logic [DATA_W-1:0] src_data [STAGES];

    // A stall or flush at stage s reaches every upstream stage as well.
    always_comb begin
        hold = '0;
        fl   = '0;
        for (int k = 0; k < STAGES; k++) begin
            hold[k] = |(stall_req >> k);
            fl[k]   = |(flush >> k);
        end
    end

    // A flushed stage does not really hold, so the gap below it is not counted as a bubble.
    always_comb begin
        bub = '0;
        for (int k = 1; k < STAGES; k++) begin
            bub[k] = hold[k-1] & ~fl[k-1] & ~hold[k];
        end
    end

    always_comb begin
        src_vld     = '0;
        src_vld[0]  = in_valid;
        src_pc[0]   = in_pc;
        src_data[0] = in_data;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k]  = vld_p[k-1] & ~hold[k-1];
            src_pc[k]   = pc_p[k-1];
            src_data[k] = data_p[k-1];
        end
    end

    // Stage registers and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k]  <= 1'b0;
                pc_p[k]   <= '0;
                data_p[k] <= '0;
            end
            retire_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (fl[k]) begin
                    vld_p[k] <= 1'b0;
                end else if (!hold[k]) begin
                    vld_p[k]  <= src_vld[k];
                    pc_p[k]   <= src_pc[k];
                    data_p[k] <= src_data[k];
                end
            end
            if (vld_p[STAGES-1] && !stall_req[STAGES-1]) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            if (|bub) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready    = ~hold[0];
    assign out_valid   = vld_p[STAGES-1];
    assign out_pc      = pc_p[STAGES-1];
    assign out_data    = data_p[STAGES-1];
    assign stage_valid = vld_p;

endmodule

// File: tb/tb_arm_pipe_chain.sv
// Testbench for arm_pipe_chain: directed scenarios plus randomized traffic against
// a stage-array reference model built from the chain's hold/flush/load rules.
module tb_arm_pipe_chain;
    localparam int S  = 4;
    localparam int PW = 32;
    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [PW-1:0] in_pc;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [S-1:0]  stall_req;
    logic [S-1:0]  flush;
    logic          out_valid;
    logic [PW-1:0] out_pc;
    logic [DW-1:0] out_data;
    logic [S-1:0]  stage_valid;
    logic [CW-1:0] retire_cnt;
    logic [CW-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    logic          m_v   [S];
    logic [PW-1:0] m_pc  [S];
    logic [DW-1:0] m_d   [S];
    logic [CW-1:0] m_ret;
    logic [CW-1:0] m_bub;

    always #5 clk = ~clk;

    arm_pipe_chain #(.STAGES(S), .PC_W(PW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data),
        .in_ready(in_ready), .stall_req(stall_req), .flush(flush),
        .out_valid(out_valid), .out_pc(out_pc), .out_data(out_data),
        .stage_valid(stage_valid), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
    );

    // Reference: apply one clock edge to the model using the inputs present now.
    task automatic model_edge();
        logic h [S];
        logic f [S];
        if (rst) begin
            for (int k = 0; k < S; k++) begin
                m_v[k] = 1'b0; m_pc[k] = '0; m_d[k] = '0;
            end
            m_ret = '0;
            m_bub = '0;
            return;
        end
        for (int k = 0; k < S; k++) begin
            h[k] = 1'b0;
            f[k] = 1'b0;
            for (int j = k; j < S; j++) begin
                if (stall_req[j]) h[k] = 1'b1;
                if (flush[j])     f[k] = 1'b1;
            end
        end
        if (m_v[S-1] && !stall_req[S-1]) m_ret = m_ret + CW'(1);
        for (int k = 1; k < S; k++) begin
            if (h[k-1] && !f[k-1] && !h[k]) m_bub = m_bub + CW'(1);
        end
        for (int k = S-1; k >= 0; k--) begin
            if (f[k]) begin
                m_v[k] = 1'b0;
            end else if (!h[k]) begin
                if (k == 0) begin
                    m_v[0] = in_valid; m_pc[0] = in_pc; m_d[0] = in_data;
                end else begin
                    m_v[k] = m_v[k-1] && !h[k-1]; m_pc[k] = m_pc[k-1]; m_d[k] = m_d[k-1];
                end
            end
        end
    endtask

    function automatic logic [S-1:0] m_sv();
        logic [S-1:0] v;
        for (int k = 0; k < S; k++) v[k] = m_v[k];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_pc = '0; in_data = '0; stall_req = '0; flush = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic feed(input logic [PW-1:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_data  = DW'($urandom);
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (stage_valid !== 4'b0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got stage_valid=%b out_valid=%b, want 0000/0", stage_valid, out_valid);
        end
        checks++;
        if (retire_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_counters: got retire=%0d bubble=%0d, want 0/0", retire_cnt, bubble_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        stall_req = 4'b0100;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_stalled: got %b want 0", in_ready);
        end
        rst = 1'b0;
        stall_req = '0;
    endtask

    task automatic test_straight_flow();
        logic          exp_v;
        logic [PW-1:0] exp_pc;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            in_valid = (i <= 3);
            in_pc    = PW'((i - 1) * 4);
            in_data  = DW'($urandom);
            step();
            exp_v  = (i >= 4 && i <= 6);
            exp_pc = PW'((i - 4) * 4);
            checks++;
            if (out_valid !== exp_v || (exp_v && out_pc !== exp_pc)) begin
                errors++;
                $display("FAIL straight_out edge %0d: got v=%b pc=%h, want v=%b pc=%h", i, out_valid, out_pc, exp_v, exp_pc);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (retire_cnt !== 4'd3 || bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL straight_counters: got retire=%0d bubble=%0d, want 3/0", retire_cnt, bubble_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        feed(32'h0); feed(32'h4); feed(32'h8);
        in_valid = 1'b1; in_pc = 32'hC; in_data = DW'($urandom);
        stall_req = 4'b0010;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
        step();
        checks++;
        if (stage_valid !== 4'b1011 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL stall_edge1: got sv=%b pc=%h, want 1011 pc=0", stage_valid, out_pc);
        end
        step();
        checks++;
        if (stage_valid !== 4'b0011 || bubble_cnt !== 4'd2) begin
            errors++;
            $display("FAIL stall_edge2: got sv=%b bubble=%0d, want 0011/2", stage_valid, bubble_cnt);
        end
        stall_req = '0;
        step();
        in_valid = 1'b0;
        checks++;
        if (stage_valid !== 4'b0111 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got sv=%b out_valid=%b, want 0111/0", stage_valid, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4 || retire_cnt !== 4'd1) begin
            errors++;
            $display("FAIL stall_delay: got v=%b pc=%h retire=%0d, want 1/4/1", out_valid, out_pc, retire_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        feed(32'h0); feed(32'h4); feed(32'h8); feed(32'hC);
        flush = 4'b0010;
        in_valid = 1'b1; in_pc = 32'h10; in_data = DW'($urandom);
        step();
        flush = '0; in_valid = 1'b0;
        checks++;
        if (stage_valid !== 4'b1100 || out_pc !== 32'h4 || retire_cnt !== 4'd1) begin
            errors++;
            $display("FAIL flush_edge: got sv=%b pc=%h retire=%0d, want 1100/4/1", stage_valid, out_pc, retire_cnt);
        end
        step();
        checks++;
        if (stage_valid !== 4'b1000 || out_pc !== 32'h8) begin
            errors++;
            $display("FAIL flush_after: got sv=%b pc=%h, want 1000/8", stage_valid, out_pc);
        end
        step();
        checks++;
        if (stage_valid !== 4'b0000) begin
            errors++;
            $display("FAIL flush_dropped_input: got sv=%b want 0000", stage_valid);
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        feed(32'h0); feed(32'h4); feed(32'h8); feed(32'hC);
        stall_req = 4'b0100;
        flush     = 4'b0100;
        step();
        stall_req = '0; flush = '0;
        checks++;
        if (stage_valid !== 4'b0000 || bubble_cnt !== 4'd0 || retire_cnt !== 4'd1) begin
            errors++;
            $display("FAIL stall_flush: got sv=%b bubble=%0d retire=%0d, want 0000/0/1", stage_valid, bubble_cnt, retire_cnt);
        end
    endtask

    task automatic test_rst_midstream();
        do_reset();
        feed(32'h0); feed(32'h4); feed(32'h8);
        stall_req = 4'b0010;
        step();
        rst   = 1'b1;
        flush = 4'b0001;
        step();
        rst   = 1'b0;
        flush = '0;
        checks++;
        if (stage_valid !== 4'b0000 || retire_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid: got sv=%b retire=%0d bubble=%0d, want 0000/0/0", stage_valid, retire_cnt, bubble_cnt);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_in_ready: got %b want 0", in_ready);
        end
        stall_req = '0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_in_ready_release: got %b want 1", in_ready);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= 21; i++) begin
            in_valid = (i <= 17);
            in_pc    = PW'(i * 4);
            in_data  = DW'($urandom);
            step();
            if (i == 20) begin
                checks++;
                if (retire_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL wrap_zero: got %0d want 0", retire_cnt);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (retire_cnt !== 4'd1) begin
            errors++;
            $display("FAIL wrap_final: got %0d want 1", retire_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_pc     = $urandom;
            in_data   = DW'($urandom);
            stall_req = ($urandom_range(0, 2) == 0) ? S'($urandom) : '0;
            flush     = ($urandom_range(0, 7) == 0) ? S'($urandom) : '0;
            #1;
            checks++;
            if (in_ready !== !(|stall_req)) begin
                errors++;
                $display("FAIL rand_in_ready cyc %0d: got %b stall=%b", n, in_ready, stall_req);
            end
            step();
            checks++;
            if (stage_valid !== m_sv() || out_valid !== m_v[S-1]) begin
                errors++;
                $display("FAIL rand_valid cyc %0d: got sv=%b ov=%b, want sv=%b", n, stage_valid, out_valid, m_sv());
            end
            if (m_v[S-1]) begin
                checks++;
                if (out_pc !== m_pc[S-1] || out_data !== m_d[S-1]) begin
                    errors++;
                    $display("FAIL rand_out cyc %0d: got pc=%h d=%h, want pc=%h d=%h", n, out_pc, out_data, m_pc[S-1], m_d[S-1]);
                end
            end
            checks++;
            if (retire_cnt !== m_ret || bubble_cnt !== m_bub) begin
                errors++;
                $display("FAIL rand_counters cyc %0d: got retire=%0d bubble=%0d, want %0d/%0d", n, retire_cnt, bubble_cnt, m_ret, m_bub);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_straight_flow();
        test_stall();
        test_flush();
        test_stall_flush();
        test_rst_midstream();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
